// File: rtl/gascon_permutation_iter.sv
// Iterative GASCON permutation engine: accepts a 320-bit state, applies a
// programmable run of rounds UNROLL per clock, and holds the result until
// downstream takes it.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | applying rounds, busy high
// HOLD  | result valid on cout, waiting for out_ready
module gascon_permutation_iter #(
   parameter int CWORDS64 = 5,
   parameter int ROUND_W  = 4,
   parameter int UNROLL   = 1,
   localparam int CWIDTH  = 64 * CWORDS64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CWIDTH-1:0]   c,
   input  logic [ROUND_W-1:0]  first_round,
   input  logic [ROUND_W:0]    num_rounds,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CWIDTH-1:0]   cout,
   output logic                busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   // Only the 5-word state and the listed unroll factors are supported.
   if (CWORDS64 != 5) begin : g_bad_cwords
      $error("gascon_permutation_iter: CWORDS64 must be 5");
   end
   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("gascon_permutation_iter: UNROLL must be 1, 2 or 4");
   end

   state_t              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;
   logic [CWIDTH-1:0]   r_cout;
   logic [CWIDTH-1:0]   r_work;
   logic [ROUND_W-1:0]  r_rnd;
   logic [ROUND_W:0]    r_rem;

   logic [CWIDTH-1:0]   w_stage [UNROLL+1];
   logic [ROUND_W:0]    w_k;

   function automatic logic [63:0] f_rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One full round: round constant into x2, bitsliced sbox, linear layer.
   function automatic logic [CWIDTH-1:0] f_round(input logic [CWIDTH-1:0] s,
                                                 input logic [3:0]        r);
      logic [63:0]       x [5];
      logic [63:0]       t [5];
      logic [CWIDTH-1:0] res;
      for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
      x[2] = x[2] ^ {56'h0, 4'hF - r, r};
      x[0] = x[0] ^ x[4];
      x[4] = x[4] ^ x[3];
      x[2] = x[2] ^ x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
      x[1] = x[1] ^ x[0];
      x[0] = x[0] ^ x[4];
      x[3] = x[3] ^ x[2];
      x[2] = ~x[2];
      x[0] = x[0] ^ f_rotr(x[0], 19) ^ f_rotr(x[0], 28);
      x[1] = x[1] ^ f_rotr(x[1], 61) ^ f_rotr(x[1], 39);
      x[2] = x[2] ^ f_rotr(x[2], 1)  ^ f_rotr(x[2], 6);
      x[3] = x[3] ^ f_rotr(x[3], 10) ^ f_rotr(x[3], 17);
      x[4] = x[4] ^ f_rotr(x[4], 7)  ^ f_rotr(x[4], 41);
      res = '0;
      for (int i = 0; i < 5; i++) res[64*i +: 64] = x[i];
      return res;
   endfunction

   assign w_stage[0] = r_work;

   // Round chain; stage g is skipped once the remaining count is exhausted.
   for (genvar g = 0; g < UNROLL; g++) begin : g_round
      logic [ROUND_W-1:0] w_idx;
      logic [CWIDTH-1:0]  w_rnd_out;
      assign w_idx       = r_rnd + ROUND_W'(g);
      assign w_rnd_out   = f_round(w_stage[g], 4'(w_idx));
      assign w_stage[g+1] = (r_rem > (ROUND_W+1)'(g)) ? w_rnd_out : w_stage[g];
   end

   // Rounds consumed this RUN cycle.
   assign w_k = (r_rem > (ROUND_W+1)'(UNROLL)) ? (ROUND_W+1)'(UNROLL) : r_rem;

   // Control FSM with registered handshake outputs and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_cout      <= '0;
         r_work      <= '0;
         r_rnd       <= '0;
         r_rem       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_work     <= c;
                  r_rnd      <= first_round;
                  r_rem      <= num_rounds;
                  if (num_rounds == '0) begin
                     r_cout      <= c;
                     r_out_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_work <= w_stage[UNROLL];
               r_rnd  <= r_rnd + ROUND_W'(w_k);
               r_rem  <= r_rem - w_k;
               if (r_rem == w_k) begin
                  r_cout      <= w_stage[UNROLL];
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign cout      = r_cout;

endmodule

// File: tb/tb_gascon_permutation_iter.sv
// Bench for gascon_permutation_iter: three builds (UNROLL 1, 2, 4) share the
// same stimulus; results are compared against a behavioural round model.
module tb_gascon_permutation_iter;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         out_ready;
   logic [319:0] c;
   logic [3:0]   first_round;
   logic [4:0]   num_rounds;
   logic [2:0]   in_ready_v;
   logic [2:0]   out_valid_v;
   logic [2:0]   busy_v;
   logic [319:0] cout_v [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [319:0] res;
      int           n;
   } exp_t;
   exp_t exp_q [$];

   logic [319:0] obs_cout  [3];
   int           obs_busy  [3];
   int           obs_first [3];
   bit           obs_done  [3];
   int           un        [3];

   always #5 clk = ~clk;

   gascon_permutation_iter #(.CWORDS64(5), .ROUND_W(4), .UNROLL(1)) u_u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
      .c(c), .first_round(first_round), .num_rounds(num_rounds),
      .out_valid(out_valid_v[0]), .out_ready(out_ready), .cout(cout_v[0]), .busy(busy_v[0]));
   gascon_permutation_iter #(.CWORDS64(5), .ROUND_W(4), .UNROLL(2)) u_u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
      .c(c), .first_round(first_round), .num_rounds(num_rounds),
      .out_valid(out_valid_v[1]), .out_ready(out_ready), .cout(cout_v[1]), .busy(busy_v[1]));
   gascon_permutation_iter #(.CWORDS64(5), .ROUND_W(4), .UNROLL(4)) u_u4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
      .c(c), .first_round(first_round), .num_rounds(num_rounds),
      .out_valid(out_valid_v[2]), .out_ready(out_ready), .cout(cout_v[2]), .busy(busy_v[2]));

   function automatic logic [63:0] m_rotr(input logic [63:0] v, input int n);
      logic [127:0] d;
      d = {v, v} >> n;
      return d[63:0];
   endfunction

   function automatic logic [319:0] m_perm(input logic [319:0] s, input int fr, input int n);
      logic [63:0]  x [5];
      logic [63:0]  t [5];
      int           ra [5];
      int           rb [5];
      int           idx;
      logic [319:0] o;
      ra = '{19, 61, 1, 10, 7};
      rb = '{28, 39, 6, 17, 41};
      for (int w = 0; w < 5; w++) x[w] = s[64*w +: 64];
      for (int r = 0; r < n; r++) begin
         idx  = (fr + r) % 16;
         x[2] = x[2] ^ 64'(((15 - idx) << 4) | idx);
         x[0] = x[0] ^ x[4];
         x[4] = x[4] ^ x[3];
         x[2] = x[2] ^ x[1];
         for (int j = 0; j < 5; j++) t[j] = ~x[j] & x[(j + 1) % 5];
         for (int j = 0; j < 5; j++) x[j] = x[j] ^ t[(j + 1) % 5];
         x[1] = x[1] ^ x[0];
         x[0] = x[0] ^ x[4];
         x[3] = x[3] ^ x[2];
         x[2] = ~x[2];
         for (int j = 0; j < 5; j++) x[j] = x[j] ^ m_rotr(x[j], ra[j]) ^ m_rotr(x[j], rb[j]);
      end
      o = '0;
      for (int w = 0; w < 5; w++) o[64*w +: 64] = x[w];
      return o;
   endfunction

   function automatic int exp_busy(input int n, input int u);
      return (n + u - 1) / u;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int w = 0; w < 10; w++) v[32*w +: 32] = $urandom();
      return v;
   endfunction

   // Present one request, queue its expected result, then scramble the inputs.
   task automatic send(input logic [319:0] cin, input int fr, input int n, input bit rdy);
      exp_t e;
      @(negedge clk);
      in_valid    = 1'b1;
      c           = cin;
      first_round = 4'(fr);
      num_rounds  = 5'(n);
      out_ready   = rdy;
      e.res = m_perm(cin, fr, n);
      e.n   = n;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      c           = rand320();
      first_round = 4'($urandom());
      num_rounds  = 5'($urandom());
   endtask

   // Watch all builds until each shows out_valid or the budget runs out.
   task automatic collect(input int budget);
      for (int i = 0; i < 3; i++) begin
         obs_done[i] = 1'b0; obs_busy[i] = 0; obs_first[i] = 0; obs_cout[i] = '0;
      end
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (obs_done[0] && obs_done[1] && obs_done[2]) break;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!obs_done[i]) begin
               if (busy_v[i]) obs_busy[i]++;
               if (out_valid_v[i]) begin
                  obs_done[i]  = 1'b1;
                  obs_cout[i]  = cout_v[i];
                  obs_first[i] = cyc;
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      c = '0; first_round = '0; num_rounds = '0;
      #12;
      total++;
      if (out_valid_v !== 3'b000) begin
         bad++; $display("FAIL reset_out_valid got=%b want=000", out_valid_v);
      end
      total++;
      if (busy_v !== 3'b000) begin
         bad++; $display("FAIL reset_busy got=%b want=000", busy_v);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (cout_v[i] !== 320'h0) begin
            bad++; $display("FAIL reset_cout[u%0d] got=%h want=0", un[i], cout_v[i]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready_v !== 3'b111) begin
         bad++; $display("FAIL reset_in_ready got=%b want=111", in_ready_v);
      end
   endtask

   task automatic test_zero_rounds();
      exp_t e;
      logic [319:0] cin;
      cin = {5{64'h0123456789ABCDEF}};
      send(cin, 3, 0, 1'b1);
      collect(50);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs_done[i] !== 1'b1 || obs_cout[i] !== cin || obs_first[i] !== 1 || obs_busy[i] !== 0) begin
            bad++;
            $display("FAIL zero_rounds[u%0d] done=%0d first=%0d busy=%0d cout=%h want first=1 busy=0 cout=%h",
                     un[i], obs_done[i], obs_first[i], obs_busy[i], obs_cout[i], e.res);
         end
      end
   endtask

   task automatic test_single_round();
      exp_t e;
      send('0, 0, 1, 1'b1);
      collect(50);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs_done[i] !== 1'b1 || obs_cout[i] !== e.res) begin
            bad++; $display("FAIL single_round_cout[u%0d] got=%h want=%h", un[i], obs_cout[i], e.res);
         end
         total++;
         if (obs_busy[i] !== 1 || obs_first[i] !== 2) begin
            bad++; $display("FAIL single_round_lat[u%0d] busy=%0d first=%0d want busy=1 first=2",
                            un[i], obs_busy[i], obs_first[i]);
         end
      end
   endtask

   // Shared by the multi-round scenarios: one request, full result checks.
   task automatic test_rounds(input string name, input logic [319:0] cin, input int fr, input int n);
      exp_t e;
      send(cin, fr, n, 1'b1);
      collect(50);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs_done[i] !== 1'b1 || obs_cout[i] !== e.res) begin
            bad++; $display("FAIL %s_cout[u%0d] got=%h want=%h", name, un[i], obs_cout[i], e.res);
         end
         total++;
         if (obs_busy[i] !== exp_busy(e.n, un[i]) || obs_first[i] !== exp_busy(e.n, un[i]) + 1) begin
            bad++; $display("FAIL %s_lat[u%0d] busy=%0d first=%0d want busy=%0d first=%0d", name,
                            un[i], obs_busy[i], obs_first[i], exp_busy(e.n, un[i]), exp_busy(e.n, un[i]) + 1);
         end
      end
   endtask

   task automatic test_full_and_wrap();
      test_rounds("full12", rand320(), 4, 12);
      test_rounds("seven", rand320(), 5, 7);
      test_rounds("wrap14", rand320(), 14, 4);
      test_rounds("max16", rand320(), 9, 16);
   endtask

   task automatic test_backpressure();
      exp_t e;
      send(rand320(), 6, 5, 1'b0);
      collect(50);
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs_done[i] !== 1'b1 || obs_cout[i] !== e.res) begin
            bad++; $display("FAIL bp_result[u%0d] got=%h want=%h", un[i], obs_cout[i], e.res);
         end
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         c          = rand320();
         num_rounds = 5'($urandom_range(0, 16));
         total++;
         if (out_valid_v !== 3'b111 || in_ready_v !== 3'b000 || busy_v !== 3'b000) begin
            bad++; $display("FAIL bp_hold_flags cyc=%0d valid=%b ready=%b busy=%b want 111/000/000",
                            k, out_valid_v, in_ready_v, busy_v);
         end
         for (int i = 0; i < 3; i++) begin
            total++;
            if (cout_v[i] !== e.res) begin
               bad++; $display("FAIL bp_cout_stable[u%0d] got=%h want=%h", un[i], cout_v[i], e.res);
            end
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready_v !== 3'b111 || out_valid_v !== 3'b000 || busy_v !== 3'b000) begin
         bad++; $display("FAIL bp_release ready=%b valid=%b busy=%b want 111/000/000",
                         in_ready_v, out_valid_v, busy_v);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (cout_v[i] !== e.res) begin
            bad++; $display("FAIL bp_cout_kept[u%0d] got=%h want=%h", un[i], cout_v[i], e.res);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      @(negedge clk);
      in_valid = 1'b1; c = rand320(); first_round = 4'd4; num_rounds = 5'd12; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      total++;
      if (out_valid_v !== 3'b000 || busy_v !== 3'b000) begin
         bad++; $display("FAIL abort_flags valid=%b busy=%b want 000/000", out_valid_v, busy_v);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (cout_v[i] !== 320'h0) begin
            bad++; $display("FAIL abort_cout[u%0d] got=%h want=0", un[i], cout_v[i]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid_v !== 3'b000) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL abort_no_valid got=1 want=0");
      end
      test_rounds("after_abort", rand320(), 4, 12);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 5; k++) begin
         test_rounds("b2b", rand320(), int'($urandom_range(0, 15)), int'($urandom_range(1, 16)));
      end
   endtask

   initial begin
      un = '{1, 2, 4};
      test_reset();
      test_zero_rounds();
      test_single_round();
      test_full_and_wrap();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
